// File: rtl/decode_scoreboard.sv
// decode_scoreboard: per-register outstanding-write scoreboard for the ID stage.
// Tracks cycles until each architectural register's pending result can be forwarded.
// Raises a stall for RAW hazards (source not yet forwardable) and for WAW hazards
// (older write would land after the new one). Flush squashes the producer issued
// last cycle and kills the ID instruction.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   issue_valid/we/rd/lat        - instruction leaving ID into EX this cycle
//   rs_id/rt_id, rs_used/rt_used - source operands of the instruction in ID
//   flush                        - kill ID instruction and last cycle's issue
//   stall/hold_pc/hold_if/bubble - hazard outputs, all identical
//   busy_mask, pending_count     - which registers have an outstanding write, and how many
module decode_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int LAT_W     = 3,
  parameter int MAX_LAT   = 6,
  parameter int FWD_READY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic [REG_AW-1:0]   rs_id,
  input  logic [REG_AW-1:0]   rt_id,
  input  logic                rs_used,
  input  logic                rt_used,
  input  logic                flush,
  output logic                stall,
  output logic                hold_pc,
  output logic                hold_if,
  output logic                bubble,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [REG_AW:0]     pending_count
);

  // Cycles remaining until each register's result is available; entry 0 stays zero.
  logic [LAT_W-1:0]  cnt [NUM_REGS];
  logic              last_valid;
  logic [REG_AW-1:0] last_rd;

  logic [LAT_W-1:0]  rs_cnt, rt_cnt, rd_cnt, eff_lat;
  logic              raw_rs, raw_rt, waw, do_issue;

  // Register 0 and out-of-range indices read as idle.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    rd_cnt = '0;
    if (rs_id != '0 && int'(rs_id) < NUM_REGS)       rs_cnt = cnt[rs_id];
    if (rt_id != '0 && int'(rt_id) < NUM_REGS)       rt_cnt = cnt[rt_id];
    if (issue_rd != '0 && int'(issue_rd) < NUM_REGS) rd_cnt = cnt[issue_rd];
  end

  // A zero latency still needs one cycle; long units saturate at MAX_LAT.
  always_comb begin
    eff_lat = issue_lat;
    if (issue_lat == '0)                  eff_lat = LAT_W'(1);
    else if (issue_lat > LAT_W'(MAX_LAT)) eff_lat = LAT_W'(MAX_LAT);
  end

  always_comb begin
    raw_rs   = rs_used && (rs_cnt > LAT_W'(FWD_READY));
    raw_rt   = rt_used && (rt_cnt > LAT_W'(FWD_READY));
    // Older write landing after the new one would leave a stale value behind.
    waw      = issue_we && (rd_cnt > eff_lat);
    stall    = issue_valid && !flush && (raw_rs || raw_rt || waw);
    do_issue = issue_valid && !stall && !flush && issue_we && (issue_rd != '0);
  end

  assign hold_pc = stall;
  assign hold_if = stall;
  assign bubble  = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      last_valid <= 1'b0;
      last_rd    <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        // Flush and a new issue never coincide, since issuing requires no flush.
        if (flush && last_valid && last_rd == REG_AW'(r))
          cnt[r] <= '0;
        else if (do_issue && issue_rd == REG_AW'(r))
          cnt[r] <= eff_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
      last_valid <= do_issue;
      last_rd    <= issue_rd;
    end
  end

  always_comb begin
    busy_mask     = '0;
    pending_count = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_mask[r]  = (cnt[r] != '0);
      pending_count = pending_count + (REG_AW+1)'(busy_mask[r]);
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a model that records the
// absolute cycle at which each register's result becomes available.
module tb_decode_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, issue_we = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [2:0]  issue_lat = '0;
  logic [4:0]  rs_id = '0, rt_id = '0;
  logic        rs_used = 1'b0, rt_used = 1'b0, flush = 1'b0;
  logic        stall, hold_pc, hold_if, bubble;
  logic [31:0] busy_mask;
  logic [5:0]  pending_count;

  decode_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .rs_id(rs_id), .rt_id(rt_id),
    .rs_used(rs_used), .rt_used(rt_used), .flush(flush), .stall(stall),
    .hold_pc(hold_pc), .hold_if(hold_if), .bubble(bubble),
    .busy_mask(busy_mask), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: ready_at[r] is the cycle number from which register r is idle.
  longint ready_at [32];
  longint now = 0;
  bit     m_last_valid = 0;
  int     m_last_rd = 0;
  bit     exp_stall = 0;

  function automatic longint rem(input int r);
    if (r == 0) return 0;
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic int eff(input int l);
    if (l == 0) return 1;
    if (l > 6) return 6;
    return l;
  endfunction

  initial for (int i = 0; i < 32; i++) ready_at[i] = 0;

  always @(negedge clk) begin
    bit          e_stall, e_iss;
    logic [31:0] e_mask;
    int          e_pend;
    e_stall = issue_valid && !flush &&
              ((rs_used && rem(int'(rs_id)) > 1) ||
               (rt_used && rem(int'(rt_id)) > 1) ||
               (issue_we && rem(int'(issue_rd)) > eff(int'(issue_lat))));
    e_mask = '0;
    e_pend = 0;
    for (int r = 1; r < 32; r++)
      if (rem(r) != 0) begin
        e_mask[r] = 1'b1;
        e_pend++;
      end
    chk("stall", stall, e_stall);
    chk("hold_pc", hold_pc, e_stall);
    chk("hold_if", hold_if, e_stall);
    chk("bubble", bubble, e_stall);
    chk("busy_mask", busy_mask, e_mask);
    chk("pending_count", pending_count, e_pend);
    exp_stall = e_stall;
    e_iss = issue_valid && !e_stall && !flush && issue_we && issue_rd != 0;
    if (rst) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      m_last_valid = 0;
      m_last_rd = 0;
    end else begin
      if (flush && m_last_valid) ready_at[m_last_rd] = 0;
      if (e_iss) ready_at[issue_rd] = now + 1 + eff(int'(issue_lat));
      m_last_valid = e_iss;
      m_last_rd = int'(issue_rd);
    end
    now++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input int rd, input int lat,
                       input int rs, input int rt, input bit rsu, input bit rtu,
                       input bit fl);
    issue_valid = v;  issue_we = we;
    issue_rd = 5'(rd); issue_lat = 3'(lat);
    rs_id = 5'(rs);   rt_id = 5'(rt);
    rs_used = rsu;    rt_used = rtu;
    flush = fl;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  // Counts cycles the current (held) ID instruction stalls, then lets it issue.
  task automatic count_stalls(output int n);
    n = 0;
    #1;
    while (stall && n < 20) begin
      n++;
      tick();
      #1;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL stall_timeout: still stalled after %0d cycles", n);
    end
    tick();
  endtask

  int n;

  initial begin
    repeat (2) tick();
    #1;
    chk("reset_busy", busy_mask, 0);
    chk("reset_pending", pending_count, 0);
    chk("reset_stall", stall, 0);
    rst = 1'b0;

    // 1: ALU result forwards immediately.
    drive(1, 1, 5, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 5, 0, 1, 0, 0); #1;
    chk("t1_stall", stall, 0);
    chk("t1_busy5", busy_mask[5], 1);
    tick(); #1;
    chk("t1_busy_clear", busy_mask, 0);
    idle(2);

    // 2: load-use gives exactly one bubble.
    drive(1, 1, 8, 2, 0, 8, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 8, 0, 1, 0); #1;
    chk("t2_stall", stall, 1);
    chk("t2_pend", pending_count, 1);
    tick(); #1;
    chk("t2_stall_clear", stall, 0);
    tick(); #1;
    chk("t2_pend_clear", pending_count, 0);
    idle(2);

    // 3: divide latency 6 -> five stall cycles; unused rs never stalls.
    drive(1, 1, 3, 6, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 3, 0, 0, 0, 0); #1;
    chk("t3_unused", stall, 0);
    drive(1, 1, 7, 1, 3, 0, 1, 0, 0);
    count_stalls(n);
    chk("t3_stall_cycles", n, 5);
    #1;
    chk("t3_dep_issued", busy_mask[7], 1);
    idle(8);

    // 4: WAW waits until the older write is forwardable.
    drive(1, 1, 4, 6, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 4, 1, 0, 0, 0, 0, 0);
    count_stalls(n);
    chk("t4_stall_cycles", n, 5);
    #1;
    chk("t4_busy4", busy_mask[4], 1);
    chk("t4_pend", pending_count, 1);
    idle(8);

    // 5: flush squashes the previous issue and kills the ID instruction.
    drive(1, 1, 9, 6, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 11, 3, 9, 0, 1, 0, 1); #1;
    chk("t5_flush_stall", stall, 0);
    tick(); #1;
    chk("t5_busy", busy_mask, 0);
    drive(1, 1, 0, 5, 0, 0, 1, 1, 0); tick(); #1;
    chk("t5_r0_busy", busy_mask, 0);
    chk("t5_r0_stall", stall, 0);
    idle(2);

    // 6: reset mid-operation clears everything.
    drive(1, 1, 1, 6, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 2, 6, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 3, 6, 0, 0, 0, 0, 0); tick(); #1;
    chk("t6_pend3", pending_count, 3);
    drive(1, 0, 0, 0, 1, 2, 1, 1, 0);
    rst = 1'b1; tick(); #1;
    chk("t6_busy", busy_mask, 0);
    chk("t6_pend", pending_count, 0);
    chk("t6_stall", stall, 0);
    rst = 1'b0;
    idle(2);

    // Random traffic; a stalled ID instruction is held unless flushed.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (exp_stall && !flush) begin
        flush = ($urandom_range(0, 19) == 0);
      end else begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
              $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 19) == 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
Parametrised successor to the single-cycle load-use hazard detector in the decode stage. It tracks every architectural register with an outstanding write and generates an ID stall when a source operand cannot yet be forwarded. It supports multi-cycle producers such as loads, multiply/divide and future long-latency units. It sits in ID, in parallel with register-file read, and drives the PC/IF hold and the control-unit bubble mux.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never tracked
REG_AW, 5, register index width; must satisfy 2**REG_AW >= NUM_REGS
LAT_W, 3, width of per-register latency counter and of issue_lat
MAX_LAT, 6, saturation value for issued latency; must be <= 2**LAT_W-1
FWD_READY, 1, counter value at or below which the result is reachable via forwarding, so no stall is needed

Ports:
clk  in  1  pipeline clock
rst  in  1  reset
issue_valid  in  1  instruction in ID is being issued into EX this cycle
issue_we  in  1  issuing instruction writes a register
issue_rd  in  REG_AW  destination register of issuing instruction
issue_lat  in  LAT_W  cycles until result is available; loads=2, ALU=1, mul/div up to MAX_LAT
rs_id  in  REG_AW  source register rs of instruction in ID
rt_id  in  REG_AW  source register rt of instruction in ID
rs_used  in  1  instruction in ID reads rs
rt_used  in  1  instruction in ID reads rt
flush  in  1  kill instruction in ID and the instruction issued last cycle (branch taken)
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
hold_pc  out  1  equals stall
hold_if  out  1  equals stall
bubble  out  1  equals stall; selects zeroed control bits
busy_mask  out  NUM_REGS  bit r set when cnt[r] != 0
pending_count  out  REG_AW+1  population count of busy_mask

Behaviour:
- Reset is synchronous and active-high on rst, sampled on posedge clk.
- Reset values: all cnt[r]=0, last_valid=0, last_rd=0. Consequently stall/hold_pc/hold_if/bubble=0, busy_mask=0, pending_count=0.
- State per register r = 1..NUM_REGS-1: cnt[r], LAT_W bits. Register 0 is never written; cnt[0] reads as 0.
- All outputs are combinational from current state and inputs. No extra latency.
- raw_rs = rs_used & rs_id!=0 & cnt[rs_id] > FWD_READY. raw_rt is defined the same way for rt.
- waw = issue_we & issue_rd!=0 & cnt[issue_rd] > eff_lat, where eff_lat = clamp(issue_lat, 1, MAX_LAT). An issue_lat of 0 is treated as 1.
- stall = issue_valid & ~flush & (raw_rs | raw_rt | waw).
- do_issue = issue_valid & ~stall & ~flush & issue_we & issue_rd!=0.
- Each posedge:
  - every nonzero cnt decrements by 1;
  - if do_issue, cnt[issue_rd] <= eff_lat. Issue wins over decrement on the same register.
- last_valid <= do_issue; last_rd <= issue_rd.
- flush: if last_valid and flush, cnt[last_rd] <= 0 (squashed producer). The ID instruction is not issued, and last_valid <= 0. If flush coincides with a do_issue to the same register, it cannot occur, because do_issue requires ~flush.
- Counters never underflow: 0 stays 0.
- pending_count range is 0..NUM_REGS-1.
- A stall holds ID inputs stable, and the stalled instruction re-evaluates each cycle until the hazard clears.
- For the default parameters, a load (lat 2) followed by a dependent instruction gives exactly one stall cycle, matching the legacy single-bubble behaviour.

Test Plan:
1. Reset, then ALU issue rd=5 lat=1 with next instr rs=5 -> stall=0 every cycle; busy_mask[5]=1 for one cycle then 0.
2. Load rd=8 lat=2, next instr rt=8 rt_used=1 -> stall=1 for exactly 1 cycle, then 0; pending_count 1->0.
3. Div rd=3 lat=6, then instr reading rs=3 -> stall=1 for 5 cycles; dependent issues on cycle 6. An instr reading rs=3 with rs_used=0 -> no stall.
4. WAW: div rd=4 lat=6, next instr ALU rd=4 lat=1 -> stall until cnt[4]<=1, then issue with cnt[4]=1.
5. Issue rd=9 lat=6, then flush next cycle -> cnt[9]=0, busy_mask=0, and the ID instruction is not recorded; rs=0/rd=0 traffic never sets busy_mask[0].
6. Reset asserted mid-operation with 3 busy registers -> next cycle busy_mask=0, pending_count=0, stall=0.
